// File: rtl/axi_rd_arbiter_if.sv
// ============================================================================
// Module : axi_ar / axi_r
// Brief  : AXI read address and read data channel bundles with master/slave views.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface axi_ar;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    modport master (output arid, araddr, arlen, arsize, arburst, arvalid, input arready);
    modport slave  (input arid, araddr, arlen, arsize, arburst, arvalid, output arready);
endinterface

interface axi_r;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (output rid, rdata, rresp, rlast, rvalid, input rready);
    modport slave  (input rid, rdata, rresp, rlast, rvalid, output rready);
endinterface

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module : axi_rd_arbiter
// Brief  : Two-requester AXI read arbiter, one burst in flight, ARLEN length check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_rd_arbiter #(
    parameter int MAX_LEN = 8,
    parameter int FAIR_RR = 1
) (
    input  logic  clk,
    input  logic  rst,
    axi_ar.slave  m0_ar,
    axi_r.master  m0_r,
    axi_ar.slave  m1_ar,
    axi_r.master  m1_r,
    axi_ar.master s_ar,
    axi_r.slave   s_r,
    output logic  len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state_q;
    logic               grant_q;
    logic               rr_ptr_q;
    logic               len_err_q;
    logic [MAX_LEN-1:0] len_q;
    logic [MAX_LEN-1:0] beat_cnt_q;

    logic       grant_d;
    logic       gnt_arvalid;
    logic       gnt_rready;
    logic [7:0] gnt_arlen;
    logic       in_addr;
    logic       in_data;
    logic       ar_hs;
    logic       r_hs;
    logic       cnt_hit;

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);

    // Round-robin only matters on contention; a lone requester always wins.
    assign grant_d = (m0_ar.arvalid && m1_ar.arvalid)
                   ? ((FAIR_RR != 0) ? rr_ptr_q : 1'b0)
                   : m1_ar.arvalid;

    assign gnt_arvalid = grant_q ? m1_ar.arvalid : m0_ar.arvalid;
    assign gnt_rready  = grant_q ? m1_r.rready   : m0_r.rready;
    assign gnt_arlen   = grant_q ? m1_ar.arlen   : m0_ar.arlen;

    assign s_ar.arid    = grant_q ? m1_ar.arid    : m0_ar.arid;
    assign s_ar.araddr  = grant_q ? m1_ar.araddr  : m0_ar.araddr;
    assign s_ar.arlen   = gnt_arlen;
    assign s_ar.arsize  = grant_q ? m1_ar.arsize  : m0_ar.arsize;
    assign s_ar.arburst = grant_q ? m1_ar.arburst : m0_ar.arburst;
    assign s_ar.arvalid = in_addr && gnt_arvalid;

    assign m0_ar.arready = in_addr && !grant_q && s_ar.arready;
    assign m1_ar.arready = in_addr &&  grant_q && s_ar.arready;

    assign ar_hs   = s_ar.arvalid && s_ar.arready;
    assign r_hs    = in_data && s_r.rvalid && s_r.rready;
    assign cnt_hit = (beat_cnt_q == len_q);

    assign s_r.rready = in_data && gnt_rready;

    // A burst cut short by the counter still looks properly terminated upstream.
    assign m0_r.rid    = s_r.rid;
    assign m0_r.rdata  = s_r.rdata;
    assign m0_r.rresp  = s_r.rresp;
    assign m0_r.rlast  = s_r.rlast || cnt_hit;
    assign m0_r.rvalid = in_data && !grant_q && s_r.rvalid;

    assign m1_r.rid    = s_r.rid;
    assign m1_r.rdata  = s_r.rdata;
    assign m1_r.rresp  = s_r.rresp;
    assign m1_r.rlast  = s_r.rlast || cnt_hit;
    assign m1_r.rvalid = in_data && grant_q && s_r.rvalid;

    assign len_err = len_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            len_err_q  <= 1'b0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_ar.arvalid || m1_ar.arvalid) begin
                        grant_q  <= grant_d;
                        rr_ptr_q <= ~grant_d;
                        state_q  <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_q      <= MAX_LEN'(gnt_arlen);
                        beat_cnt_q <= '0;
                        state_q    <= DATA;
                    end else if (!gnt_arvalid) begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + MAX_LEN'(1);
                        if (s_r.rlast || cnt_hit) begin
                            state_q   <= IDLE;
                            len_err_q <= (s_r.rlast != cnt_hit);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module : tb_axi_rd_arbiter
// Brief  : Scoreboard bench; instance 0 round-robin, instance 1 fixed priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        arvalid [2][2];
    logic [31:0] araddr  [2][2];
    logic [7:0]  arlen   [2][2];
    logic        arready [2][2];
    logic        rready  [2][2];
    logic        rvalid  [2][2];
    logic [31:0] rdata   [2][2];
    logic        rlast   [2][2];
    logic [3:0]  rid     [2][2];
    logic        s_arready [2];
    logic        s_arvalid [2];
    logic [31:0] s_araddr  [2];
    logic [7:0]  s_arlen   [2];
    logic [3:0]  s_arid    [2];
    logic        s_rvalid  [2];
    logic [31:0] s_rdata   [2];
    logic        s_rlast   [2];
    logic [3:0]  s_rid     [2];
    logic        s_rready  [2];
    logic        len_err   [2];

    logic [32:0] rexp_q [2][2][$];
    int          gq     [2][$];
    logic [31:0] exp_addr [2][2];
    logic [7:0]  exp_len  [2][2];
    bit          tog      [2][2];
    int          lmode    [2];
    int          ar_stall [2];
    int          lerr_cnt [2];
    int          spur     [2];
    int          ptr      [2];

    for (genvar k = 0; k < 2; k++) begin : g_inst
        axi_ar m0_ar ();
        axi_ar m1_ar ();
        axi_r  m0_r ();
        axi_r  m1_r ();
        axi_ar s_ar ();
        axi_r  s_r ();

        assign m0_ar.arid    = 4'hA;
        assign m0_ar.araddr  = araddr[k][0];
        assign m0_ar.arlen   = arlen[k][0];
        assign m0_ar.arsize  = 3'd2;
        assign m0_ar.arburst = 2'b01;
        assign m0_ar.arvalid = arvalid[k][0];
        assign arready[k][0] = m0_ar.arready;
        assign m1_ar.arid    = 4'hB;
        assign m1_ar.araddr  = araddr[k][1];
        assign m1_ar.arlen   = arlen[k][1];
        assign m1_ar.arsize  = 3'd2;
        assign m1_ar.arburst = 2'b01;
        assign m1_ar.arvalid = arvalid[k][1];
        assign arready[k][1] = m1_ar.arready;

        assign m0_r.rready = rready[k][0];
        assign rvalid[k][0] = m0_r.rvalid;
        assign rdata[k][0]  = m0_r.rdata;
        assign rlast[k][0]  = m0_r.rlast;
        assign rid[k][0]    = m0_r.rid;
        assign m1_r.rready = rready[k][1];
        assign rvalid[k][1] = m1_r.rvalid;
        assign rdata[k][1]  = m1_r.rdata;
        assign rlast[k][1]  = m1_r.rlast;
        assign rid[k][1]    = m1_r.rid;

        assign s_ar.arready = s_arready[k];
        assign s_arvalid[k] = s_ar.arvalid;
        assign s_araddr[k]  = s_ar.araddr;
        assign s_arlen[k]   = s_ar.arlen;
        assign s_arid[k]    = s_ar.arid;
        assign s_r.rvalid   = s_rvalid[k];
        assign s_r.rdata    = s_rdata[k];
        assign s_r.rlast    = s_rlast[k];
        assign s_r.rid      = s_rid[k];
        assign s_r.rresp    = 2'b00;
        assign s_rready[k]  = s_r.rready;

        axi_rd_arbiter #(
            .MAX_LEN (8),
            .FAIR_RR ((k == 0) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .m0_ar   (m0_ar),
            .m0_r    (m0_r),
            .m1_ar   (m1_ar),
            .m1_r    (m1_r),
            .s_ar    (s_ar),
            .s_r     (s_r),
            .len_err (len_err[k])
        );

        for (genvar j = 0; j < 2; j++) begin : g_m
            initial master_drv(k, j);
            initial r_mon(k, j);
        end
        initial fabric_run(k);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic master_drv(input int k, input int j);
        logic hs;
        forever begin
            @(negedge clk);
            hs = arvalid[k][j] && arready[k][j];
            if (rst && arready[k][j] && !arvalid[k][j]) spur[k]++;
            @(posedge clk);
            #1;
            if (hs || !rst) arvalid[k][j] = 1'b0;
            rready[k][j] = tog[k][j] ? ~rready[k][j] : 1'b1;
        end
    endtask

    task automatic r_mon(input int k, input int j);
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst && rvalid[k][j] && rready[k][j]) begin
                if (rexp_q[k][j].size() == 0) begin
                    spur[k]++;
                end else begin
                    e = rexp_q[k][j].pop_front();
                    check_eq("r_data", rdata[k][j], e[31:0]);
                    check_eq("r_last", rlast[k][j], e[32]);
                    check_eq("r_id", rid[k][j], 4'hA + j);
                end
            end
        end
    endtask

    task automatic fabric_run(input int k);
        int phase = 0, stall = 0, beat = 0, nb = 0, jexp;
        logic ar_hs, r_hs, arv;
        logic [31:0] addr, a_s;
        logic [7:0]  l_s;
        logic [3:0]  id, id_s;
        s_arready[k] = 1'b0; s_rvalid[k] = 1'b0; s_rlast[k] = 1'b0;
        s_rdata[k] = '0; s_rid[k] = '0; addr = '0; id = '0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid[k] && s_arready[k];
            r_hs  = s_rvalid[k] && s_rready[k];
            arv   = s_arvalid[k];
            a_s = s_araddr[k]; l_s = s_arlen[k]; id_s = s_arid[k];
            if (len_err[k]) lerr_cnt[k]++;
            if (rst && ar_hs) begin
                if (gq[k].size() == 0) begin
                    spur[k]++;
                end else begin
                    jexp = gq[k].pop_front();
                    check_eq("ar_id", id_s, 4'hA + jexp);
                    check_eq("ar_addr", a_s, exp_addr[k][jexp]);
                    check_eq("ar_len", l_s, exp_len[k][jexp]);
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                phase = 0; stall = 0;
                s_arready[k] = 1'b0; s_rvalid[k] = 1'b0; s_rlast[k] = 1'b0;
            end else if (phase == 0) begin
                if (ar_hs) begin
                    s_arready[k] = 1'b0;
                    addr = a_s; id = id_s; beat = 0; stall = 0;
                    nb = (lmode[k] == 1) ? 1 : int'(l_s) + 1;
                    phase = 1;
                end else if (arv) begin
                    if (stall >= ar_stall[k]) s_arready[k] = 1'b1;
                    else stall++;
                end
            end else if (r_hs) begin
                beat++;
                if (beat == nb) begin
                    s_rvalid[k] = 1'b0; s_rlast[k] = 1'b0; phase = 0;
                end
            end
            if (rst && phase == 1) begin
                s_rvalid[k] = 1'b1;
                s_rdata[k]  = addr + 32'(beat);
                s_rid[k]    = id;
                s_rlast[k]  = (lmode[k] == 1) ? 1'b1 : (lmode[k] == 2) ? 1'b0 : (beat == nb - 1);
            end
        end
    endtask

    task automatic req(input int k, input int j, input logic [31:0] a, input logic [7:0] l, input int nb);
        araddr[k][j] = a; arlen[k][j] = l; arvalid[k][j] = 1'b1;
        exp_addr[k][j] = a; exp_len[k][j] = l;
        for (int i = 0; i < nb; i++) rexp_q[k][j].push_back({(i == nb - 1), a + 32'(i)});
    endtask

    task automatic wait_done(input int k, input string tag);
        int n = 0;
        while ((rexp_q[k][0].size() != 0 || rexp_q[k][1].size() != 0 || gq[k].size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, (n >= 500), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_quiet(input int k, input string tag);
        check_eq({tag, "_s_arvalid"}, s_arvalid[k], 0);
        check_eq({tag, "_s_rready"}, s_rready[k], 0);
        check_eq({tag, "_m0_arready"}, arready[k][0], 0);
        check_eq({tag, "_m1_arready"}, arready[k][1], 0);
        check_eq({tag, "_m0_rvalid"}, rvalid[k][0], 0);
        check_eq({tag, "_m1_rvalid"}, rvalid[k][1], 0);
        check_eq({tag, "_len_err"}, len_err[k], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, w, base;
        for (int k = 0; k < 2; k++) begin
            lmode[k] = 0; ar_stall[k] = 0; lerr_cnt[k] = 0; spur[k] = 0; ptr[k] = 0;
            for (int j = 0; j < 2; j++) begin
                arvalid[k][j] = 1'b0; araddr[k][j] = '0; arlen[k][j] = '0;
                rready[k][j] = 1'b1; tog[k][j] = 1'b0;
            end
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst1");
        @(posedge clk); #1; rst = 1'b1;

        // Single burst with address-latency check
        @(posedge clk); #1;
        gq[0].push_back(0); ptr[0] = 1;
        req(0, 0, 32'h8000_0010, 8'd1, 2);
        @(negedge clk); check_eq("t1_lat_n", s_arvalid[0], 0);
        @(negedge clk); check_eq("t1_lat_n1", s_arvalid[0], 1);
        n = 0;
        while (!(rvalid[0][0] && rready[0][0] && rlast[0][0]) && n < 100) begin
            @(negedge clk); n++;
        end
        check_eq("t1_last_timeout", (n >= 100), 0);
        @(negedge clk);
        check_eq("t1_idle_s_rready", s_rready[0], 0);
        check_eq("t1_idle_m0_rvalid", rvalid[0][0], 0);
        wait_done(0, "t1");
        check_eq("t1_len_err", lerr_cnt[0], 0);

        // Round-robin contention
        for (int it = 0; it < 4; it++) begin
            @(posedge clk); #1;
            w = ptr[0];
            gq[0].push_back(w); gq[0].push_back(1 - w);
            req(0, 0, 32'h1000_0000 + 32'(it * 64), 8'(it % 3), it % 3 + 1);
            req(0, 1, 32'h2000_0000 + 32'(it * 64), 8'((it + 1) % 3), (it + 1) % 3 + 1);
            wait_done(0, "t2");
        end

        // Fixed priority on instance 1
        for (int it = 0; it < 3; it++) begin
            @(posedge clk); #1;
            gq[1].push_back(0); gq[1].push_back(1);
            req(1, 0, 32'h3000_0000 + 32'(it * 16), 8'd1, 2);
            req(1, 1, 32'h4000_0000 + 32'(it * 16), 8'd0, 1);
            wait_done(1, "t3");
        end
        @(posedge clk); #1;
        gq[1].push_back(1);
        req(1, 1, 32'h4000_1000, 8'd2, 3);
        wait_done(1, "t3_solo");
        check_eq("t3_len_err", lerr_cnt[1], 0);

        // Early rlast
        @(posedge clk); #1;
        lmode[0] = 1; base = lerr_cnt[0];
        gq[0].push_back(0); ptr[0] = 1;
        req(0, 0, 32'h5000_0000, 8'd1, 1);
        wait_done(0, "t4");
        check_eq("t4_len_err_pulses", lerr_cnt[0] - base, 1);

        // Missing rlast, forced by counter
        @(posedge clk); #1;
        lmode[0] = 2; base = lerr_cnt[0];
        gq[0].push_back(1); ptr[0] = 0;
        req(0, 1, 32'h6000_0000, 8'd1, 2);
        wait_done(0, "t5");
        check_eq("t5_len_err_pulses", lerr_cnt[0] - base, 1);
        lmode[0] = 0;

        // Backpressure; m1 held during m0's burst
        @(posedge clk); #1;
        ar_stall[0] = 5; tog[0][0] = 1'b1; base = lerr_cnt[0];
        gq[0].push_back(0);
        req(0, 0, 32'h7000_0000, 8'd3, 4);
        @(posedge clk); #1;
        gq[0].push_back(1); ptr[0] = 0;
        req(0, 1, 32'h7100_0000, 8'd2, 3);
        wait_done(0, "t6");
        check_eq("t6_len_err", lerr_cnt[0] - base, 0);
        tog[0][0] = 1'b0; ar_stall[0] = 0;

        // Reset in the middle of a data burst
        @(posedge clk); #1;
        gq[0].push_back(0); ptr[0] = 1;
        req(0, 0, 32'h9000_0000, 8'd3, 4);
        n = 0;
        while (rexp_q[0][0].size() > 3 && n < 100) begin
            @(negedge clk); n++;
        end
        check_eq("t7_beat1_timeout", (n >= 100), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk_quiet(0, "t7_rst0");
        chk_quiet(1, "t7_rst1");
        rexp_q[0][0].delete(); gq[0].delete(); ptr[0] = 0;
        @(posedge clk); @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        gq[0].push_back(0); gq[0].push_back(1);
        req(0, 0, 32'hA000_0000, 8'd0, 1);
        req(0, 1, 32'hB000_0000, 8'd0, 1);
        wait_done(0, "t7_after");

        check_eq("spurious_events_0", spur[0], 0);
        check_eq("spurious_events_1", spur[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI read master port (AR/R) between two requesters, e.g. the instruction-side and data-side fakecache read paths, before the bus fabric.
- Allows one outstanding read burst at a time and uses round-robin grant between the two requesters.
- Routes R beats back to the granted requester and checks burst length against ARLEN.

Parameters:
- MAX_LEN, 8, width of the internal beat counter; must be at least 8 so any AXI4 ARLEN (up to 255) fits.
- FAIR_RR, 1, selects arbitration policy. 1 = round-robin. 0 = fixed priority, master 0 wins.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert outside the block.
- m0_ar  axi_ar.slave  intf  read address channel from requester 0.
- m0_r  axi_r.master  intf  read data channel to requester 0.
- m1_ar  axi_ar.slave  intf  read address channel from requester 1.
- m1_r  axi_r.master  intf  read data channel to requester 1.
- s_ar  axi_ar.master  intf  read address channel to the fabric.
- s_r  axi_r.slave  intf  read data channel from the fabric.
- len_err  output  1  one-cycle pulse when a burst's beat count disagrees with its ARLEN.

Behaviour:
- State machine with three states:
  - IDLE: no request owns the port.
  - ADDR: the address is presented to the fabric.
  - DATA: data beats are returned to the owner.
- Reset (rst=0, any state, including mid-burst):
  - state=IDLE, grant=0, rr_ptr=0 (master 0 preferred next), beat_cnt=0, len_err=0.
  - All valid and ready outputs are 0: s_ar.arvalid, s_r.rready, m*_ar.arready, m*_r.rvalid.
  - In-flight bursts are abandoned; no completion is generated.
- IDLE:
  - Both m*_ar.arready are 0.
  - If any m*_ar.arvalid is 1, the grant is registered and the state moves to ADDR on the next edge.
  - With FAIR_RR=1 and both requesting, the master selected by rr_ptr wins.
  - A single requester always wins.
- Grant update: the loser becomes rr_ptr when the grant is taken, so the last winner has lowest priority next time.
- ADDR:
  - All s_ar fields equal the granted master's AR fields, passed combinationally.
  - ARID is forwarded unmodified.
  - s_ar.arvalid = granted arvalid.
  - granted arready = s_ar.arready; the other master's arready = 0.
  - On the handshake: latch arlen, clear beat_cnt, go to DATA.
  - If the granted master drops arvalid before the handshake (protocol violation), return to IDLE. No assertion is required.
- DATA:
  - granted m_r carries s_r rdata/rresp/rid/rlast, with rvalid = s_r.rvalid.
  - s_r.rready = granted rready.
  - The other master's rvalid = 0.
  - beat_cnt increments on each R handshake.
- Burst end: an R handshake where rlast=1 OR beat_cnt==latched arlen.
  - The state returns to IDLE on the next edge.
- Length check: len_err pulses 1 cycle after the end beat if rlast and (beat_cnt==arlen) differ.
  - A burst terminated by the counter has its rlast forced to 1 toward the master.
- Latency:
  - arvalid seen in IDLE at cycle N gives s_ar.arvalid at N+1.
  - The first possible new grant is the cycle after the last beat's handshake, i.e. one idle bubble between bursts.
- Simultaneous events:
  - A new arvalid during ADDR or DATA is held off (arready=0) until IDLE.
  - A master whose arvalid is held continues to be considered at the next IDLE.
- Masters not granted never see arready or rvalid asserted.

Test Plan:
- Single burst: m0 arvalid, araddr=0x8000_0010, arlen=1; fabric returns 2 beats 0x11, 0x22 with rlast on beat 2 -> m0 receives both beats in order, m1 sees no rvalid, state is IDLE 1 cycle after the last beat, len_err=0.
- Contention, FAIR_RR=1: m0 and m1 assert arvalid in the same cycle repeatedly for 4 bursts each -> grant order 0,1,0,1,...; no master is granted twice in a row while the other is waiting.
- Fixed priority, FAIR_RR=0: both requesting -> m0 wins every time; m1 is granted only when m0 is idle.
- Length mismatch, rlast early: arlen=1, fabric asserts rlast on beat 1 -> burst ends after 1 beat, len_err pulses once.
- Length mismatch, no rlast: arlen=1, fabric omits rlast on beat 2 -> rlast is forced to 1 toward the master, len_err pulses once.
- Backpressure: s_ar.arready low for 5 cycles, then granted master's rready toggles per beat -> no beat lost or duplicated; m1 arvalid held throughout is served next.
- Reset mid-DATA: drive rst=0 after beat 1 of a 4-beat burst -> all valid/ready outputs are 0 immediately; after release, the first grant goes to m0.
